adc_spi_master: RTL and testbench

Parametrised 3-wire SPI master for configuring the ADC front-end devices: AD9253 and follow-on parts sharing its instruction/address/data frame. Serves several chip selects from one clock/data pair and accepts requests through a valid/ready handshake. Returns read data with a response strobe. Sits between the register/command decoder and the top-level SDIO tri-state buffer; one instance drives every ADC on a shared SPI bus.

---
 rtl/adc_spi_master.sv | 210 +++++++++++++++++++++
 tb/tb_adc_spi_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_master.sv
// adc_spi_master: 3-wire SPI master for AD9253-style R/W + W1:W0 + address + data frames.
// Define ADC_SPI_READ_EN to build the read path (SDIO turnaround and capture); otherwise reads are rejected.
module adc_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 4,
  parameter int CS_GAP  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd,
  input  logic [3:0]        req_cs,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [NUM_CS-1:0] spi_csn,
  output logic              spi_clk,
  output logic              spi_sdio_o,
  output logic              spi_sdio_oe,
  input  logic              spi_sdio_i
);

  // state    | meaning
  // S_IDLE   | ready for a request, bus idle
  // S_SETUP  | chip select low, first frame bit on SDIO, CLK_DIV cycles
  // S_SHIFT  | one bit per 2*CLK_DIV cycles, spi_clk high in the second half
  // S_HOLD   | chip select still low after the last falling edge, CLK_DIV cycles
  // S_GAP    | chip select high, CS_GAP cycles; read response on the last one
  // S_REJECT | single-cycle error response, no bus activity

  localparam int HDR     = 3 + ADDR_W;
  localparam int NBITS   = HDR + DATA_W;
  localparam int PH_W    = $clog2(2 * CLK_DIV);
  localparam int BIT_W   = $clog2(NBITS);
  localparam int TMR_MAX = (CS_GAP > CLK_DIV) ? CS_GAP : CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [TMR_W-1:0] TMR_DIV  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_GAP  = TMR_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_REJECT
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [TMR_W-1:0]   tmr;
  logic [PH_W-1:0]    phase;
  logic [BIT_W-1:0]   bit_cnt;
  logic [NBITS-1:0]   shreg;
  logic [NUM_CS-1:0]  csn_q;
  logic               clk_q;
  logic               reject_req;
  logic               tmr_done;
  logic               ph_last;
  logic               bit_last;
  logic               gap_rsp;
  logic [NBITS-1:0]   frame_word;

  assign tmr_done = (tmr == '0);
  assign ph_last  = (phase == PH_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);

  // Read frames carry zeros in the data field; the slave owns SDIO by then.
  assign frame_word = {req_rd, 2'b00, req_addr, (req_rd ? {DATA_W{1'b0}} : req_wdata)};

  always_comb begin
    reject_req = ({1'b0, req_cs} >= 5'(NUM_CS));
`ifndef ADC_SPI_READ_EN
    if (req_rd) reject_req = 1'b1;
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (req_valid) state_n = reject_req ? S_REJECT : S_SETUP;
      S_REJECT: state_n = S_IDLE;
      S_SETUP:  if (tmr_done) state_n = S_SHIFT;
      S_SHIFT:  if (ph_last && bit_last) state_n = S_HOLD;
      S_HOLD:   if (tmr_done) state_n = S_GAP;
      S_GAP:    if (tmr_done) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tmr     <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      csn_q   <= '1;
      clk_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (req_valid && !reject_req) begin
            tmr   <= TMR_DIV;
            shreg <= frame_word;
            csn_q <= ~(NUM_CS'(1) << req_cs);
          end
        end
        S_SETUP: begin
          if (tmr_done) begin
            phase   <= '0;
            bit_cnt <= '0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_SHIFT: begin
          if (phase == PH_RISE) clk_q <= 1'b1;
          if (ph_last) begin
            // Wrap: falling edge and next bit launched together.
            clk_q   <= 1'b0;
            phase   <= '0;
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_last) tmr <= TMR_DIV;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        S_HOLD: begin
          if (tmr_done) begin
            csn_q <= '1;
            tmr   <= TMR_GAP;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_GAP: begin
          if (!tmr_done) tmr <= tmr - TMR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ADC_SPI_READ_EN
  localparam logic [BIT_W-1:0] BIT_HDR_LAST = BIT_W'(HDR - 1);

  logic              rd_q;
  logic              oe_q;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 1'b0;
      oe_q  <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && !reject_req) begin
            rd_q  <= req_rd;
            oe_q  <= 1'b1;
            rdata <= '0;
          end
        end
        S_SHIFT: begin
          // Capture on the cycle spi_clk goes high, data bits only.
          if (rd_q && (phase == PH_RISE) && (bit_cnt > BIT_HDR_LAST))
            rdata <= {rdata[DATA_W-2:0], spi_sdio_i};
          if (ph_last && ((rd_q && (bit_cnt == BIT_HDR_LAST)) || bit_last))
            oe_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign spi_sdio_oe = oe_q;
  assign gap_rsp     = rd_q;
  assign rsp_rdata   = ((state == S_GAP) && tmr_done && rd_q) ? rdata : '0;
`else
  logic sdio_i_unused;

  assign sdio_i_unused = spi_sdio_i;
  assign spi_sdio_oe   = ~&csn_q;
  assign gap_rsp       = 1'b0;
  assign rsp_rdata     = '0;
`endif

  assign req_ready  = (state == S_IDLE);
  assign busy       = ~req_ready;
  assign rsp_err    = (state == S_REJECT);
  assign rsp_valid  = (state == S_REJECT) || ((state == S_GAP) && tmr_done && gap_rsp);
  assign spi_csn    = csn_q;
  assign spi_clk    = clk_q;
  assign spi_sdio_o = shreg[NBITS-1];

endmodule

// File: tb/tb_adc_spi_master.sv
// tb_adc_spi_master: randomized requests, expected responses and frames queued at issue time,
// checked by independent response and SPI-bus monitors; a second instance runs with CLK_DIV=2.
module tb_adc_spi_master;
  localparam int CLK_DIV   = 4;
  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 8;
  localparam int NUM_CS    = 4;
  localparam int CS_GAP    = 20;
  localparam int HDR       = 3 + ADDR_W;
  localparam int NB        = HDR + DATA_W;
  localparam int FRAME_CYC = CLK_DIV * (2 * NB + 2);
`ifdef ADC_SPI_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_rd = 1'b0;
  logic [3:0]        req_cs = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [NUM_CS-1:0] spi_csn;
  logic              spi_clk;
  logic              spi_sdio_o;
  logic              spi_sdio_oe;
  logic              spi_sdio_i = 1'b0;

  logic              req2_valid = 1'b0;
  logic              req2_ready;
  logic              req2_rd = 1'b0;
  logic [3:0]        req2_cs = '0;
  logic [ADDR_W-1:0] req2_addr = '0;
  logic [DATA_W-1:0] req2_wdata = '0;
  logic              rsp2_valid;
  logic              rsp2_err;
  logic [DATA_W-1:0] rsp2_rdata;
  logic              busy2;
  logic [NUM_CS-1:0] csn2;
  logic              sclk2;
  logic              sdo2;
  logic              oe2;
  logic              sdi2 = 1'b0;

  adc_spi_master #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_cs(req_cs), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy), .spi_csn(spi_csn), .spi_clk(spi_clk),
    .spi_sdio_o(spi_sdio_o), .spi_sdio_oe(spi_sdio_oe), .spi_sdio_i(spi_sdio_i));

  adc_spi_master #(.CLK_DIV(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS), .CS_GAP(CS_GAP)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req2_valid), .req_ready(req2_ready), .req_rd(req2_rd),
    .req_cs(req2_cs), .req_addr(req2_addr), .req_wdata(req2_wdata), .rsp_valid(rsp2_valid),
    .rsp_err(rsp2_err), .rsp_rdata(rsp2_rdata), .busy(busy2), .spi_csn(csn2), .spi_clk(sclk2),
    .spi_sdio_o(sdo2), .spi_sdio_oe(oe2), .spi_sdio_i(sdi2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit err; int data; int cyc; } rsp_t;
  typedef struct { bit rd; int cs; int bits; int acc; } frm_t;
  rsp_t rsp_q[$];
  frm_t frm_q[$];
  rsp_t re;
  frm_t fe;

  int tests = 0;
  int fails = 0;
  int inv_err = 0;
  bit mon_en = 1'b0;
  bit aborting = 1'b0;
  int slave_data = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: R/W, W1:W0=00, address, data (zeros for reads), MSB first.
  function automatic int model_bits(input bit rd, input int addr, input int wdata);
    return (int'(rd) << (NB - 1)) | (addr << DATA_W) | (rd ? 0 : wdata);
  endfunction

  // Called at a negedge; returns one negedge after acceptance with req_valid still high.
  task automatic issue(input bit rd, input int cs, input int addr, input int wdata,
                       input int sdata, output int acc);
    bit rej;
    req_rd = rd; req_cs = 4'(cs); req_addr = ADDR_W'(addr); req_wdata = DATA_W'(wdata);
    req_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    chk("accept", int'(req_ready), 1);
    acc = cyc;
    slave_data = sdata;
    rej = (cs >= NUM_CS) || (rd && !READ_EN);
    if (rej) begin
      rsp_q.push_back('{1'b1, 0, acc + 1});
    end else begin
      frm_q.push_back('{rd, cs, model_bits(rd, addr, wdata), acc});
      if (rd) rsp_q.push_back('{1'b0, sdata, acc + FRAME_CYC + CS_GAP});
    end
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int acc, input int exp);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, cyc - acc, exp);
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (mon_en && !rst && rsp_valid) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        re = rsp_q.pop_front();
        chk("rsp_err", int'(rsp_err), int'(re.err));
        chk("rsp_rdata", int'(rsp_rdata), re.data);
        chk("rsp_cycle", cyc, re.cyc);
      end
    end
  end

  // Bus monitor plus SDIO slave model
  bit prev_clk = 1'b0;
  bit in_frame = 1'b0;
  bit f_rd = 1'b0;
  int f_len, f_rises, f_falls, f_bits, f_oe_fall, f_csn, f_start;
  int last_rise_cyc = -1000;
  int last_gap = -1;
  logic [NUM_CS-1:0] lo;

  always @(negedge clk) begin
    if (mon_en) begin
      lo = ~spi_csn;
      if ((lo & (lo - 1'b1)) != 0) inv_err++;
      if (lo == 0 && (spi_sdio_oe || spi_clk)) inv_err++;
      if (aborting) begin
        in_frame = 1'b0;
        spi_sdio_i = 1'b0;
      end else begin
        if (!in_frame && lo != 0) begin
          in_frame = 1'b1; f_start = cyc; f_len = 0; f_rises = 0; f_falls = 0;
          f_bits = 0; f_oe_fall = -1; f_csn = int'(spi_csn);
          last_gap = cyc - last_rise_cyc;
          f_rd = (frm_q.size() > 0) ? frm_q[0].rd : 1'b0;
        end
        if (in_frame) begin
          if (lo != 0) begin
            f_len++;
            if (!prev_clk && spi_clk) begin
              f_rises++;
              f_bits = (f_bits << 1) | int'(spi_sdio_o);
            end
            if (prev_clk && !spi_clk) begin
              f_falls++;
              if (f_rd && f_falls >= HDR && f_falls < NB)
                spi_sdio_i = slave_data[DATA_W - 1 - (f_falls - HDR)];
            end
            if (!spi_sdio_oe && f_oe_fall < 0) f_oe_fall = f_falls;
          end else begin
            in_frame = 1'b0;
            last_rise_cyc = cyc;
            spi_sdio_i = 1'b0;
            if (frm_q.size() == 0) chk("frame_unexpected", 1, 0);
            else begin
              fe = frm_q.pop_front();
              chk("csn_value", f_csn, (~(1 << fe.cs)) & ((1 << NUM_CS) - 1));
              chk("csn_start", f_start, fe.acc + 1);
              chk("frame_len", f_len, FRAME_CYC);
              chk("clk_rises", f_rises, NB);
              if (fe.rd) chk("hdr_bits", f_bits >> DATA_W, fe.bits >> DATA_W);
              else chk("frame_bits", f_bits, fe.bits);
              chk("oe_fall_bit", f_oe_fall, fe.rd ? HDR : (READ_EN ? NB : -1));
            end
          end
        end
      end
    end
    prev_clk = spi_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2;
    int len2, r2, bits2, last_r, pmin, pmax, a2, d2;
    bit p2;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_csn", int'(spi_csn), 15);
    chk("rst_spi_clk", int'(spi_clk), 0);
    chk("rst_sdio_o", int'(spi_sdio_o), 0);
    chk("rst_sdio_oe", int'(spi_sdio_oe), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Write cs=2 addr 0x0008 data 0x03
    issue(1'b0, 2, 'h0008, 'h03, 0, acc);
    req_valid = 1'b0;
    wait_ready("write_ready_return", acc, FRAME_CYC + CS_GAP + 1);

    // Read cs=0 addr 0x0001, slave returns 0x93 (rejected when reads are compiled out)
    issue(1'b1, 0, 'h0001, 0, 'h93, acc);
    req_valid = 1'b0;
    wait_ready("read_ready_return", acc, READ_EN ? FRAME_CYC + CS_GAP + 1 : 2);

    // Out-of-range chip select
    issue(1'b0, 5, 'h0123, 'h55, 0, acc);
    req_valid = 1'b0;
    wait_ready("reject_ready_return", acc, 2);
    repeat (5) @(negedge clk);

    // Back-to-back writes with req_valid held high
    issue(1'b0, 1, 'h0abc, 'h5a, 0, acc1);
    issue(1'b0, 3, 'h1fff, 'ha5, 0, acc2);
    req_valid = 1'b0;
    chk("b2b_accept_spacing", acc2 - acc1, FRAME_CYC + CS_GAP + 1);
    wait_ready("b2b_ready_return", acc2, FRAME_CYC + CS_GAP + 1);
    chk("b2b_csn_high_gap", last_gap, CS_GAP + 1);

    // Reset during bit 10 of a frame
    issue(READ_EN, 1, 'h0777, 'hc3, 'h3c, acc);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2000 && f_rises < 10; i++) @(negedge clk);
    aborting = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_csn", int'(spi_csn), 15);
    chk("abort_spi_clk", int'(spi_clk), 0);
    chk("abort_sdio_oe", int'(spi_sdio_oe), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    rsp_q.delete();
    frm_q.delete();
    @(negedge clk);
    aborting = 1'b0;
    issue(1'b0, 0, 'h0042, 'h99, 0, acc);
    req_valid = 1'b0;
    wait_ready("post_reset_ready_return", acc, FRAME_CYC + CS_GAP + 1);

    // Randomized traffic
    for (int k = 0; k < 14; k++) begin
      bit rd;
      int cs;
      rd = 1'($urandom % 2);
      cs = ($urandom % 4 == 0) ? 4 + int'($urandom % 2) : int'($urandom % 4);
      issue(rd, cs, int'($urandom % 8192), int'($urandom % 256), int'($urandom % 256), acc);
      if ($urandom % 2 == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    wait_ready("random_drain", acc, cyc - acc);
    repeat (4) @(negedge clk);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    chk("frame_queue_empty", frm_q.size(), 0);

    // CLK_DIV=2 instance: one write
    a2 = int'($urandom % 8192);
    d2 = int'($urandom % 256);
    req2_rd = 1'b0; req2_cs = 4'd3; req2_addr = ADDR_W'(a2); req2_wdata = DATA_W'(d2);
    req2_valid = 1'b1;
    chk("div2_ready", int'(req2_ready), 1);
    @(negedge clk);
    req2_valid = 1'b0;
    len2 = 0; r2 = 0; bits2 = 0; last_r = -1; pmin = 1000; pmax = 0; p2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (csn2 != 4'hf) len2++;
      if (!p2 && sclk2) begin
        if (last_r >= 0) begin
          if (cyc - last_r < pmin) pmin = cyc - last_r;
          if (cyc - last_r > pmax) pmax = cyc - last_r;
        end
        last_r = cyc;
        bits2 = (bits2 << 1) | int'(sdo2);
        r2++;
      end
      p2 = sclk2;
      if (len2 > 0 && csn2 == 4'hf) break;
      @(negedge clk);
    end
    chk("div2_frame_len", len2, 2 * (2 * NB + 2));
    chk("div2_period_min", pmin, 4);
    chk("div2_period_max", pmax, 4);
    chk("div2_rises", r2, NB);
    chk("div2_bits", bits2, model_bits(1'b0, a2, d2));
    chk("div2_no_rsp", int'(rsp2_valid), 0);

    chk("bus_invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
